// File: rtl/reg_writeback_ctrl.sv
// -----------------------------------------------------------------------------
// reg_writeback_ctrl
//
// Write-back buffer sitting between an execution pipeline and a register
// file. Requests are queued in a DEPTH-entry circular FIFO of {idx, data} and
// retired to the register file in push order, one per cycle, whenever the
// register file is not stalled. A drain handshake lets the pipeline stop new
// requests and wait until every queued write has landed.
//
// Optional feature (compile-time macro REG_WRITEBACK_BYPASS_EN):
//   When defined, a combinational bypass reports whether any pending entry
//   targets RD_IDX and returns the newest pending value for it. When not
//   defined, RD_HIT/RD_DATA are tied to zero and no compare logic exists.
//
// Parameters
//   DEPTH  buffer entry count, power of two in 2..16
//   DW     data width
//
// Ports
//   CLK       clock, all state changes on the rising edge
//   CLR       asynchronous active-low reset
//   WR_VALID  write-back request valid
//   WR_IDX    destination register R0..R15
//   WR_DATA   write-back value
//   WR_READY  buffer can accept a request (registered state only)
//   DRAIN     stop accepting and empty the buffer
//   DRAINED   one-cycle pulse when a drain completes
//   RF_STALL  register file cannot take a write this cycle
//   RF_WE_N   active-low register-file write enable
//   RF_REGEN  register index for the register-file enable decoder
//   RF_DATA   data to the register-file D inputs
//   RD_IDX    bypass lookup index
//   RD_HIT    a pending entry matches RD_IDX
//   RD_DATA   newest pending value for RD_IDX
// -----------------------------------------------------------------------------
module reg_writeback_ctrl #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          WR_VALID,
    input  logic [3:0]    WR_IDX,
    input  logic [DW-1:0] WR_DATA,
    output logic          WR_READY,
    input  logic          DRAIN,
    output logic          DRAINED,
    input  logic          RF_STALL,
    output logic          RF_WE_N,
    output logic [3:0]    RF_REGEN,
    output logic [DW-1:0] RF_DATA,
    input  logic [3:0]    RD_IDX,
    output logic          RD_HIT,
    output logic [DW-1:0] RD_DATA
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic [3:0]    idx_mem  [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];

    logic          push;
    logic          pop;
    logic          accept;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_RUN:   if (DRAIN) state_next = ST_DRAIN;
            // Exit once the buffer is observed empty; an empty buffer on entry
            // still spends exactly one cycle here.
            ST_DRAIN: if (count == '0) state_next = ST_DONE;
            ST_DONE:  state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (registered state only, so WR_READY never depends on inputs)
    // -------------------------------------------------------------------------
    always_comb begin
        accept  = 1'b0;
        DRAINED = 1'b0;
        unique case (state)
            ST_RUN:   accept  = 1'b1;
            ST_DRAIN: accept  = 1'b0;
            ST_DONE:  DRAINED = 1'b1;
            default:  accept  = 1'b0;
        endcase
    end

    assign WR_READY = accept && (count < FULL_COUNT);

    // -------------------------------------------------------------------------
    // Push / pop qualification
    // -------------------------------------------------------------------------
    // A pushed entry is only visible to commit after the edge that stores it,
    // giving the one-cycle minimum latency from an empty buffer.
    assign push = WR_VALID && WR_READY;
    assign pop  = (count != '0) && !RF_STALL;

    // -------------------------------------------------------------------------
    // Pointers and occupancy
    // -------------------------------------------------------------------------
    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; occupancy alone decides which
    // slots are meaningful, so clearing the contents would buy nothing.
    always_ff @(posedge CLK) begin
        if (push) begin
            idx_mem[tail]  <= WR_IDX;
            data_mem[tail] <= WR_DATA;
        end
    end

    // -------------------------------------------------------------------------
    // Register-file commit port
    // -------------------------------------------------------------------------
    // pop depends on count, which reset clears asynchronously, so a reset
    // mid-commit drops RF_WE_N without waiting for a clock.
    always_comb begin
        RF_WE_N  = 1'b1;
        RF_REGEN = 4'd0;
        RF_DATA  = '0;
        if (pop) begin
            RF_WE_N  = 1'b0;
            RF_REGEN = idx_mem[head];
            RF_DATA  = data_mem[head];
        end
    end

    // -------------------------------------------------------------------------
    // Bypass lookup
    // -------------------------------------------------------------------------
`ifdef REG_WRITEBACK_BYPASS_EN
    // Walk from oldest (head) to newest; a later match overrides an earlier
    // one, so the newest pending value wins. The head entry is included even
    // while it is being committed.
    always_comb begin
        RD_HIT  = 1'b0;
        RD_DATA = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && (idx_mem[head + AW'(i)] == RD_IDX)) begin
                RD_HIT  = 1'b1;
                RD_DATA = data_mem[head + AW'(i)];
            end
        end
    end
`else
    logic unused_rd_idx;

    assign unused_rd_idx = ^RD_IDX;
    assign RD_HIT        = 1'b0;
    assign RD_DATA       = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_writeback_ctrl
//
// Self-checking bench for reg_writeback_ctrl. The reference model is a queue
// of pending writes plus a three-valued drain phase. Every accepted push
// appends the expected commit to a scoreboard queue; an independent monitor
// pops and compares whenever the DUT asserts RF_WE_N.
// -----------------------------------------------------------------------------
module tb_reg_writeback_ctrl;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          CLK;
    logic          CLR;
    logic          WR_VALID;
    logic [3:0]    WR_IDX;
    logic [DW-1:0] WR_DATA;
    logic          WR_READY;
    logic          DRAIN;
    logic          DRAINED;
    logic          RF_STALL;
    logic          RF_WE_N;
    logic [3:0]    RF_REGEN;
    logic [DW-1:0] RF_DATA;
    logic [3:0]    RD_IDX;
    logic          RD_HIT;
    logic [DW-1:0] RD_DATA;

    reg_writeback_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .WR_VALID (WR_VALID),
        .WR_IDX   (WR_IDX),
        .WR_DATA  (WR_DATA),
        .WR_READY (WR_READY),
        .DRAIN    (DRAIN),
        .DRAINED  (DRAINED),
        .RF_STALL (RF_STALL),
        .RF_WE_N  (RF_WE_N),
        .RF_REGEN (RF_REGEN),
        .RF_DATA  (RF_DATA),
        .RD_IDX   (RD_IDX),
        .RD_HIT   (RD_HIT),
        .RD_DATA  (RD_DATA)
    );

    typedef struct packed {
        logic [3:0]    idx;
        logic [DW-1:0] data;
    } ent_t;

    ent_t expq[$];   // scoreboard: commits the DUT still owes
    ent_t pend[$];   // model: entries held in the buffer
    int   phase;     // model: 0 accepting, 1 draining, 2 drain-complete cycle
    int   errors = 0;
    int   checks = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: compares every commit the DUT presents against the scoreboard.
    always @(negedge CLK) begin
        if (CLR === 1'b1 && RF_WE_N === 1'b0) begin
            if (expq.size() == 0) begin
                check("unexpected_commit", 64'(RF_REGEN), 64'hFFFF);
            end else begin
                ent_t e;
                e = expq.pop_front();
                check("commit_idx", 64'(RF_REGEN), 64'(e.idx));
                check("commit_data", 64'(RF_DATA), 64'(e.data));
            end
        end
    end

    // One clock cycle: drive inputs, check registered-state outputs and the
    // bypass against the model, then advance the model across the edge.
    task automatic step(input logic v, input logic [3:0] idx, input logic [DW-1:0] d,
                        input logic stall, input logic drn, input logic [3:0] rd);
        bit            ready;
        bit            commit;
        bit            hit;
        logic [DW-1:0] bdata;
        int            np;
        WR_VALID = v;
        WR_IDX   = idx;
        WR_DATA  = d;
        RF_STALL = stall;
        DRAIN    = drn;
        RD_IDX   = rd;
        #1;
        ready  = (pend.size() < DEPTH) && (phase == 0);
        commit = (pend.size() > 0) && !stall;
        check("wr_ready", 64'(WR_READY), 64'(ready));
        check("drained", 64'(DRAINED), 64'(phase == 2));
        check("rf_we_n", 64'(RF_WE_N), 64'(!commit));
        if (!commit) begin
            check("rf_regen_idle", 64'(RF_REGEN), 64'd0);
            check("rf_data_idle", 64'(RF_DATA), 64'd0);
        end
        hit   = 1'b0;
        bdata = '0;
`ifdef REG_WRITEBACK_BYPASS_EN
        foreach (pend[i]) begin
            if (pend[i].idx == rd) begin
                hit   = 1'b1;
                bdata = pend[i].data;
            end
        end
`endif
        check("rd_hit", 64'(RD_HIT), 64'(hit));
        check("rd_data", 64'(RD_DATA), 64'(bdata));
        np = phase;
        case (phase)
            0: if (drn) np = 1;
            1: if (pend.size() == 0) np = 2;
            default: np = 0;
        endcase
        if (commit) void'(pend.pop_front());
        if (v && ready) begin
            pend.push_back('{idx: idx, data: d});
            expq.push_back('{idx: idx, data: d});
        end
        phase = np;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, '0, 1'b0, 1'b0, 4'd0);
    endtask

    // Empty the buffer with a bounded cycle budget.
    task automatic flush();
        int guard = 0;
        while ((pend.size() > 0 || phase != 0) && guard < 40) begin
            step(1'b0, 4'd0, '0, 1'b0, 1'b0, 4'd0);
            guard++;
        end
        check("flush_bound", 64'(pend.size() == 0 && phase == 0), 64'd1);
    endtask

    initial begin
        CLR      = 1'b0;
        WR_VALID = 1'b0;
        WR_IDX   = '0;
        WR_DATA  = '0;
        RF_STALL = 1'b0;
        DRAIN    = 1'b0;
        RD_IDX   = '0;
        phase    = 0;
        #2;
        check("reset_rf_we_n", 64'(RF_WE_N), 64'd1);
        check("reset_rf_regen", 64'(RF_REGEN), 64'd0);
        check("reset_rf_data", 64'(RF_DATA), 64'd0);
        check("reset_drained", 64'(DRAINED), 64'd0);
        check("reset_rd_hit", 64'(RD_HIT), 64'd0);
        check("reset_rd_data", 64'(RD_DATA), 64'd0);
        #10 CLR = 1'b1;
        @(posedge CLK);
        #1;

        // Single write: commits the following cycle, for one cycle only.
        step(1'b1, 4'd3, 32'h0000_00AA, 1'b0, 1'b0, 4'd3);
        idle(2);

        // Fill under stall, fifth attempt refused, then ordered release.
        for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), DW'(i), 1'b1, 1'b0, 4'd0);
        step(1'b1, 4'd9, 32'h99, 1'b1, 1'b0, 4'd2);
        idle(5);

        // Duplicate index: bypass returns the newest value.
        step(1'b1, 4'd5, 32'h11, 1'b1, 1'b0, 4'd0);
        step(1'b1, 4'd5, 32'h22, 1'b1, 1'b0, 4'd5);
        step(1'b0, 4'd0, '0, 1'b1, 1'b0, 4'd5);
        flush();

        // Drain with three entries pending.
        for (int i = 0; i < 3; i++) step(1'b1, 4'(i + 6), DW'(32'h100 + i), 1'b1, 1'b0, 4'd6);
        step(1'b1, 4'd12, 32'hDEAD, 1'b1, 1'b1, 4'd7);
        step(1'b1, 4'd12, 32'hBEEF, 1'b1, 1'b0, 4'd7);
        for (int i = 0; i < 6; i++) step(1'b0, 4'd0, '0, 1'b0, 1'b0, 4'd8);

        // Drain from empty: one DRAIN cycle, then DONE.
        step(1'b0, 4'd0, '0, 1'b0, 1'b1, 4'd0);
        idle(3);

        // Asynchronous reset between edges while committing.
        step(1'b1, 4'd10, 32'hA0, 1'b1, 1'b0, 4'd0);
        step(1'b1, 4'd11, 32'hB0, 1'b1, 1'b0, 4'd0);
        WR_VALID = 1'b0;
        RF_STALL = 1'b0;
        #1;
        check("pre_reset_commit", 64'(RF_WE_N), 64'd0);
        #1 CLR = 1'b0;
        #1;
        check("async_reset_we_n", 64'(RF_WE_N), 64'd1);
        check("async_reset_regen", 64'(RF_REGEN), 64'd0);
        expq.delete();
        pend.delete();
        phase = 0;
        @(posedge CLK);
        #2 CLR = 1'b1;
        idle(3);

        // Push and pop every cycle, wrapping the pointers.
        for (int i = 0; i < 10; i++) step(1'b1, 4'($urandom_range(15)), DW'(i), 1'b0, 1'b0, 4'd0);
        idle(2);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(99) < 70) ? 1'b1 : 1'b0,
                 4'($urandom_range(15)),
                 DW'($urandom),
                 ($urandom_range(99) < 35) ? 1'b1 : 1'b0,
                 ($urandom_range(99) < 3) ? 1'b1 : 1'b0,
                 4'($urandom_range(15)));
        end
        flush();
        idle(1);
        check("scoreboard_empty", 64'(expq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
